sigma_delta_decimator: RTL
==========================

Name: sigma_delta_decimator

Overview:
- Demodulator for the 1-bit stream produced by the team's first-order sigma-delta modulator.
- Recovers a VALUE_WIDTH-bit sample using a 2nd-order CIC (sinc^2) decimation filter with ratio R = 2**LOG2_RATIO.
- Sits on the receive side: the loopback/test path or the external-comparator return path. Output is one sample per R clocks plus a valid strobe.

Parameters:
- VALUE_WIDTH, 8: width of the recovered output sample.
- LOG2_RATIO, 5: log2 of the decimation ratio R (R = 32 by default).
  - Legal range: 2 <= LOG2_RATIO, and 2*LOG2_RATIO >= VALUE_WIDTH.
  - Violations are caught by an elaboration-time $error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  decimator enable; low synchronously clears the datapath.
- sigma_delta  input  1  bitstream, one bit per enabled clk.
- value  output  VALUE_WIDTH  recovered sample, unsigned.
- value_valid  output  1  one-cycle strobe; value is new in this cycle.
- settled  output  1  high once filter warm-up is complete.

Behaviour:
- Reset (rst_n low, async): all of the following go to 0.
  - Integrators, comb delays and decimation counter.
  - value, value_valid, settled.
  - FSM goes to IDLE.
- Internal width W = 2*LOG2_RATIO+1. Integrators and combs use modular W-bit arithmetic; wrap-around is intentional and must not saturate.
- Integrators, every clk with enable high:
  - i1 <= i1 + sigma_delta
  - i2 <= i2 + i1 (uses the old i1)
- Decimation counter cnt:
  - Counts 0..R-1 on enabled clks, wrapping to 0.
  - tick = enable & (cnt == R-1).
- Comb stage, on tick only:
  - c1 = i2 - d1
  - y = c1 - d2
  - d1 <= i2
  - d2 <= c1
- Output scaling:
  - ys = min(y, 2**(2*LOG2_RATIO) - 1), i.e. saturate full scale R^2 down by one LSB.
  - value = ys >> (2*LOG2_RATIO - VALUE_WIDTH). Truncating by default.
- FSM states IDLE, WARMUP, RUN:
  - IDLE -> WARMUP on the first clk with enable high. Counter starts at 0 in that cycle.
  - WARMUP: the first 2 ticks are discarded. value is not updated and value_valid stays 0.
  - WARMUP -> RUN on the 2nd tick.
  - RUN: every tick registers value and pulses value_valid for exactly 1 clk, on the edge after the tick cycle. settled = 1 in RUN.
- Latency: the first value_valid occurs 3R clks after enable is first sampled high. Subsequent strobes follow every R clks.
- enable low (any state, including mid-decimation), synchronously on the next edge:
  - Clear i1, i2, d1, d2 and cnt.
  - value_valid, settled and value go to 0.
  - FSM goes to IDLE.
  - Re-enable restarts warm-up from zero.
- enable low on a tick cycle: the clear wins; no strobe is emitted.
- value holds its last value between strobes.

Optional Feature:
- Macro: SD_DECIMATOR_ROUND_EN.
- Defined:
  - Round half-up before shifting: value = min(y + 2**(S-1), 2**(2*LOG2_RATIO) - 1) >> S, where S = 2*LOG2_RATIO - VALUE_WIDTH.
  - The rounded sum is computed in W+1 bits.
  - When S = 0, no rounding is applied.
- Undefined: truncation as above.
- Latency is identical in both builds.

Test Plan:
- Defaults, all-ones bitstream after reset release and enable high:
  - value_valid first at 96 clks after enable.
  - value = 255 on every strobe (y = 1024 saturates to 1023).
  - settled rises with the first strobe.
- All-zeros bitstream -> every strobe value = 0; strobe spacing exactly 32 clks.
- Alternating 1,0,1,0 -> every RUN strobe value = 128 (y = 512).
- Loopback from the modulator (VALUE_WIDTH = 8) driven with constant 64, 128, 200:
  - After settling, strobes stay within ±1 LSB of 64, 128, 200.
  - Repeat with SD_DECIMATOR_ROUND_EN defined; compare against a golden model using round-half-up.
- Deassert enable at cnt = 17 in RUN:
  - Next edge: value = 0, value_valid = 0, settled = 0.
  - Re-enable: first strobe again at 96 clks.
- Assert rst_n low asynchronously mid-window (between clock edges):
  - All outputs drop to 0 immediately.
  - After release, behaviour matches the fresh-start case.

Source files
------------

// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc^2) decimator that recovers an unsigned sample from a 1-bit sigma-delta stream.
// Latency: first value_valid 3R clocks after enable is first sampled high, then one strobe every R clocks.
// No backpressure: value_valid is a one-cycle strobe. Optional macro SD_DECIMATOR_ROUND_EN rounds half-up before the shift.
module sigma_delta_decimator #(
    parameter int VALUE_WIDTH = 8,
    parameter int LOG2_RATIO  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sigma_delta,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   value_valid,
    output logic                   settled
);
    localparam int W = 2*LOG2_RATIO + 1;
    localparam int S = 2*LOG2_RATIO - VALUE_WIDTH;
    localparam logic [LOG2_RATIO-1:0]   CNT_LAST = '1;
    localparam logic [2*LOG2_RATIO-1:0] FULL     = '1;

    if (LOG2_RATIO < 2 || 2*LOG2_RATIO < VALUE_WIDTH) begin : g_param_check
        $error("sigma_delta_decimator: need LOG2_RATIO >= 2 and 2*LOG2_RATIO >= VALUE_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            i1_q, i1_d;
    logic [W-1:0]            i2_q, i2_d;
    logic [W-1:0]            d1_q, d1_d;
    logic [W-1:0]            d2_q, d2_d;
    logic [LOG2_RATIO-1:0]   cnt_q, cnt_d;
    logic                    tick_seen_q, tick_seen_d;
    logic [VALUE_WIDTH-1:0]  value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    settled_q, settled_d;

    logic                    tick;
    logic [W-1:0]            c1;
    logic [W-1:0]            y;
    logic [2*LOG2_RATIO-1:0] ys;
    logic [VALUE_WIDTH-1:0]  scaled;

    // IDLE holds cnt at 0, so the first tick lands R edges after the IDLE->WARMUP edge.
    assign tick = enable && (state_q != IDLE) && (cnt_q == CNT_LAST);

    // Modular W-bit differences; wrap-around of the integrators cancels here.
    assign c1 = i2_q - d1_q;
    assign y  = c1 - d2_q;

`ifdef SD_DECIMATOR_ROUND_EN
    localparam int         HS   = (S > 0) ? S - 1 : 0;
    localparam logic [W:0] HALF = (S > 0) ? ((W+1)'(1) << HS) : '0;
    logic [W:0] y_rnd;
    assign y_rnd = {1'b0, y} + HALF;
    assign ys    = (y_rnd > {2'b00, FULL}) ? FULL : y_rnd[2*LOG2_RATIO-1:0];
`else
    assign ys = (y > {1'b0, FULL}) ? FULL : y[2*LOG2_RATIO-1:0];
`endif

    assign scaled = VALUE_WIDTH'(ys >> S);

    always_comb begin
        state_d     = state_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        cnt_d       = cnt_q;
        tick_seen_d = tick_seen_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        settled_d   = settled_q;

        if (!enable) begin
            state_d     = IDLE;
            i1_d        = '0;
            i2_d        = '0;
            d1_d        = '0;
            d2_d        = '0;
            cnt_d       = '0;
            tick_seen_d = 1'b0;
            value_d     = '0;
            settled_d   = 1'b0;
        end else begin
            i1_d = i1_q + W'(sigma_delta);
            i2_d = i2_q + i1_q;
            unique case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    cnt_d   = '0;
                end
                WARMUP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick) begin
                        d1_d = i2_q;
                        d2_d = c1;
                        if (tick_seen_q) begin
                            state_d     = RUN;
                            tick_seen_d = 1'b0;
                        end else begin
                            tick_seen_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick) begin
                        d1_d      = i2_q;
                        d2_d      = c1;
                        value_d   = scaled;
                        valid_d   = 1'b1;
                        settled_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i1_q        <= '0;
            i2_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            cnt_q       <= '0;
            tick_seen_q <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            settled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            cnt_q       <= cnt_d;
            tick_seen_q <= tick_seen_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            settled_q   <= settled_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign settled     = settled_q;

    // A strobe is only ever issued from RUN, and never on consecutive clocks.
    a_valid_settled: assert property (@(posedge clk) disable iff (!rst_n) value_valid |-> settled);
    a_valid_pulse:   assert property (@(posedge clk) disable iff (!rst_n) value_valid |=> !value_valid);

endmodule
